regfile_wb_ctrl: RTL and testbench

- Controls writes into the LC-3 8x16 register file (write port RD_LE/RD/DATA_IN, read selects RS1/RS2).
- Shares the single write port between two writeback requesters, ALU and MEM, using round-robin arbitration with valid/ready handshakes.
- Keeps a scoreboard of registers with loads in flight, and stalls decode reads and issue on hazards.
- Sits between the decode/execute/memory stages and register_file.

---
 rtl/lc3_pkg.sv | 20 ++
 rtl/rr_arb2.sv | 38 +++
 rtl/regfile_wb_ctrl.sv | 143 ++++++++++++++
 tb/tb_regfile_wb_ctrl.sv | 341 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lc3_pkg.sv
// Shared LC-3 register-file constants and writeback requester encoding.
package lc3_pkg;

    localparam int REG_W     = 16;
    localparam int REGADDR_W = 3;
    localparam int NUM_REGS  = 8;

    // Requester identities, used as the round-robin LAST_GRANT value.
    localparam logic GNT_ALU = 1'b0;
    localparam logic GNT_MEM = 1'b1;

    // Single-bit decode of a register address into a scoreboard mask.
    function automatic logic [NUM_REGS-1:0] regMask(input logic [REGADDR_W-1:0] addr);
        logic [NUM_REGS-1:0] mask;
        mask       = '0;
        mask[addr] = 1'b1;
        return mask;
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin arbiter (ALU vs MEM) for the register-file
// write port. Grants are combinational; only the last winner is stored.
module rr_arb2
    import lc3_pkg::*;
(
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_eligAlu,
    input  logic i_eligMem,
    output logic o_gntAlu,
    output logic o_gntMem
);

    logic r_lastGrant;
    logic w_gntAlu;
    logic w_gntMem;

    // On a tie the requester that did not win last time gets the port.
    always_comb begin
        w_gntAlu = i_eligAlu & (!i_eligMem | (r_lastGrant == GNT_MEM));
        w_gntMem = i_eligMem & (!i_eligAlu | (r_lastGrant == GNT_ALU));
    end

    // Remember the most recent winner so the next tie flips to the other side.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_lastGrant <= GNT_ALU;
        end else if (w_gntMem) begin
            r_lastGrant <= GNT_MEM;
        end else if (w_gntAlu) begin
            r_lastGrant <= GNT_ALU;
        end
    end

    assign o_gntAlu = w_gntAlu;
    assign o_gntMem = w_gntMem;

endmodule

// File: rtl/regfile_wb_ctrl.sv
// Writeback controller for the LC-3 8x16 register file: arbitrates the single
// write port between ALU and load data, tracks loads in flight, and raises
// decode/issue stalls on RAW and WAW hazards against outstanding loads.
module regfile_wb_ctrl
    import lc3_pkg::*;
#(
    parameter int MAX_LOADS = 2
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 ALU_VALID,
    input  logic [REGADDR_W-1:0] ALU_DR,
    input  logic [REG_W-1:0]     ALU_DATA,
    output logic                 ALU_READY,
    input  logic                 MEM_VALID,
    input  logic [REGADDR_W-1:0] MEM_DR,
    input  logic [REG_W-1:0]     MEM_DATA,
    output logic                 MEM_READY,
    input  logic                 ISSUE_VALID,
    input  logic [REGADDR_W-1:0] ISSUE_DR,
    output logic                 ISSUE_READY,
    input  logic                 RS1_USE,
    input  logic                 RS2_USE,
    input  logic [REGADDR_W-1:0] RS1,
    input  logic [REGADDR_W-1:0] RS2,
    output logic                 RD_STALL,
    output logic                 RF_RD_LE,
    output logic [REGADDR_W-1:0] RF_RD,
    output logic [REG_W-1:0]     RF_DATA_IN,
    output logic [REGADDR_W-1:0] RF_RS1,
    output logic [REGADDR_W-1:0] RF_RS2,
    output logic [NUM_REGS-1:0]  PENDING,
    output logic                 ERR
);

    localparam int CNT_W = $clog2(MAX_LOADS + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_LOADS);

    logic [NUM_REGS-1:0] r_pending;
    logic [CNT_W-1:0]    r_loadCount;
    logic                r_err;

    logic w_eligAlu;
    logic w_eligMem;
    logic w_gntAlu;
    logic w_gntMem;
    logic w_memClearsIssue;
    logic w_issueReady;
    logic w_issueAcc;
    logic w_memRetire;
    logic w_stall1;
    logic w_stall2;

    // An ALU result waits while a load to the same register is still in
    // flight, otherwise the older load would later overwrite it. Nothing is
    // eligible during reset so no write reaches the register file then.
    always_comb begin
        w_eligAlu = ALU_VALID & !r_pending[ALU_DR] & !RST;
        w_eligMem = MEM_VALID & !RST;
    end

    rr_arb2 u_arb (
        .i_clk     (CLK),
        .i_rst     (RST),
        .i_eligAlu (w_eligAlu),
        .i_eligMem (w_eligMem),
        .o_gntAlu  (w_gntAlu),
        .o_gntMem  (w_gntMem)
    );

    // Route the winner onto the register-file write port; idle port drives zeros.
    always_comb begin
        RF_RD_LE   = 1'b0;
        RF_RD      = '0;
        RF_DATA_IN = '0;
        if (w_gntMem) begin
            RF_RD_LE   = 1'b1;
            RF_RD      = MEM_DR;
            RF_DATA_IN = MEM_DATA;
        end else if (w_gntAlu) begin
            RF_RD_LE   = 1'b1;
            RF_RD      = ALU_DR;
            RF_DATA_IN = ALU_DATA;
        end
    end

    // Issue and decode hazard logic; a load retiring this cycle frees its
    // register and its counter slot immediately, so neither needs to stall.
    always_comb begin
        w_memClearsIssue = w_gntMem & (MEM_DR == ISSUE_DR);
        w_issueReady     = ((r_loadCount < CNT_MAX) | w_gntMem) &
                           (!r_pending[ISSUE_DR] | w_memClearsIssue);
        w_issueAcc       = ISSUE_VALID & w_issueReady;
        w_memRetire      = w_gntMem & r_pending[MEM_DR];
        w_stall1         = RS1_USE & r_pending[RS1] & !(w_gntMem & (MEM_DR == RS1));
        w_stall2         = RS2_USE & r_pending[RS2] & !(w_gntMem & (MEM_DR == RS2));
    end

    // Scoreboard update: retiring load clears first, a new issue then sets,
    // so an issue to the register being retired leaves its bit pending.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_pending <= '0;
        end else begin
            r_pending <= (r_pending & ~(w_gntMem ? regMask(MEM_DR) : '0))
                       | (w_issueAcc ? regMask(ISSUE_DR) : '0);
        end
    end

    // Outstanding-load counter. A load write to a non-pending register does
    // not decrement (no underflow); the increment saturates because an issue
    // riding on such a bogus retire could otherwise exceed the limit.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_loadCount <= '0;
        end else begin
            case ({w_issueAcc, w_memRetire})
                2'b10: if (r_loadCount != CNT_MAX) r_loadCount <= r_loadCount + CNT_W'(1);
                2'b01: r_loadCount <= r_loadCount - CNT_W'(1);
                default: r_loadCount <= r_loadCount;
            endcase
        end
    end

    // Sticky flag for load data arriving for a register with no load in flight.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_err <= 1'b0;
        end else if (w_gntMem & !r_pending[MEM_DR]) begin
            r_err <= 1'b1;
        end
    end

    assign ALU_READY   = w_gntAlu;
    assign MEM_READY   = w_gntMem;
    assign ISSUE_READY = w_issueReady;
    assign RD_STALL    = w_stall1 | w_stall2;
    assign RF_RS1      = RS1;
    assign RF_RS2      = RS2;
    assign PENDING     = r_pending;
    assign ERR         = r_err;

endmodule

// File: tb/tb_regfile_wb_ctrl.sv
// Directed bench for regfile_wb_ctrl with a write scoreboard: expected
// register-file writes are queued as stimulus is applied and a monitor pops
// them whenever the DUT asserts RF_RD_LE.
module tb_regfile_wb_ctrl;

    logic        CLK = 1'b0;
    logic        RST;
    logic        ALU_VALID;
    logic [2:0]  ALU_DR;
    logic [15:0] ALU_DATA;
    logic        ALU_READY;
    logic        MEM_VALID;
    logic [2:0]  MEM_DR;
    logic [15:0] MEM_DATA;
    logic        MEM_READY;
    logic        ISSUE_VALID;
    logic [2:0]  ISSUE_DR;
    logic        ISSUE_READY;
    logic        RS1_USE;
    logic        RS2_USE;
    logic [2:0]  RS1;
    logic [2:0]  RS2;
    logic        RD_STALL;
    logic        RF_RD_LE;
    logic [2:0]  RF_RD;
    logic [15:0] RF_DATA_IN;
    logic [2:0]  RF_RS1;
    logic [2:0]  RF_RS2;
    logic [7:0]  PENDING;
    logic        ERR;

    typedef struct packed {
        logic [2:0]  rd;
        logic [15:0] data;
    } wr_t;

    wr_t         expQ[$];
    int          checksDone   = 0;
    int          checksFailed = 0;
    logic [15:0] modelRegs [8];

    regfile_wb_ctrl #(.MAX_LOADS(2)) dut (
        .CLK         (CLK),
        .RST         (RST),
        .ALU_VALID   (ALU_VALID),
        .ALU_DR      (ALU_DR),
        .ALU_DATA    (ALU_DATA),
        .ALU_READY   (ALU_READY),
        .MEM_VALID   (MEM_VALID),
        .MEM_DR      (MEM_DR),
        .MEM_DATA    (MEM_DATA),
        .MEM_READY   (MEM_READY),
        .ISSUE_VALID (ISSUE_VALID),
        .ISSUE_DR    (ISSUE_DR),
        .ISSUE_READY (ISSUE_READY),
        .RS1_USE     (RS1_USE),
        .RS2_USE     (RS2_USE),
        .RS1         (RS1),
        .RS2         (RS2),
        .RD_STALL    (RD_STALL),
        .RF_RD_LE    (RF_RD_LE),
        .RF_RD       (RF_RD),
        .RF_DATA_IN  (RF_DATA_IN),
        .RF_RS1      (RF_RS1),
        .RF_RS2      (RF_RS2),
        .PENDING     (PENDING),
        .ERR         (ERR)
    );

    // Free-running clock, 10 time units per cycle.
    always #5 CLK = ~CLK;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checksDone++;
        if (act !== exp) begin
            checksFailed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic expectWrite(input logic [2:0] rd, input logic [15:0] data);
        wr_t e;
        e.rd   = rd;
        e.data = data;
        expQ.push_back(e);
    endtask

    // Commit the current input vector at the next rising edge, then move
    // just past it so the next vector can be driven.
    task automatic applyStimulus();
        @(posedge CLK);
        #1;
    endtask

    task automatic idleInputs();
        ALU_VALID   = 1'b0; ALU_DR   = 3'd0; ALU_DATA = 16'h0;
        MEM_VALID   = 1'b0; MEM_DR   = 3'd0; MEM_DATA = 16'h0;
        ISSUE_VALID = 1'b0; ISSUE_DR = 3'd0;
        RS1_USE     = 1'b0; RS2_USE  = 1'b0; RS1 = 3'd0; RS2 = 3'd0;
    endtask

    // Write monitor: every register-file write must match the oldest expected one.
    always @(negedge CLK) begin
        wr_t e;
        if (!RST && RF_RD_LE) begin
            if (expQ.size() == 0) begin
                checksDone++;
                checksFailed++;
                $display("[TB] FAIL unexpected_write: got rd=%0d data=0x%0h, expected no write", RF_RD, RF_DATA_IN);
            end else begin
                e = expQ.pop_front();
                checkOutput("wb_rd", {29'd0, RF_RD}, {29'd0, e.rd});
                checkOutput("wb_data", {16'd0, RF_DATA_IN}, {16'd0, e.data});
            end
            modelRegs[RF_RD] = RF_DATA_IN;
        end
    end

    // Watchdog so a broken design can never hang the run.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed stimulus sequence.
    initial begin
        for (int i = 0; i < 8; i++) modelRegs[i] = 16'h0;
        idleInputs();
        RST = 1'b1;
        repeat (2) @(posedge CLK);
        #1;
        RST = 1'b0;

        // Reset state
        @(negedge CLK);
        checkOutput("rst_alu_ready", ALU_READY, 0);
        checkOutput("rst_mem_ready", MEM_READY, 0);
        checkOutput("rst_rd_le",     RF_RD_LE,  0);
        checkOutput("rst_pending",   PENDING,   0);
        checkOutput("rst_err",       ERR,       0);
        checkOutput("rst_issue_rdy", ISSUE_READY, 1);
        applyStimulus();

        // Both requesters after reset: MEM wins first, then ALU
        ISSUE_VALID = 1'b1; ISSUE_DR = 3'd5;
        @(negedge CLK);
        checkOutput("issue5_ready", ISSUE_READY, 1);
        applyStimulus();
        ISSUE_VALID = 1'b0;
        ALU_VALID = 1'b1; ALU_DR = 3'd2; ALU_DATA = 16'h1111;
        MEM_VALID = 1'b1; MEM_DR = 3'd5; MEM_DATA = 16'h2222;
        expectWrite(3'd5, 16'h2222);
        @(negedge CLK);
        checkOutput("both_c1_mem_ready", MEM_READY, 1);
        checkOutput("both_c1_alu_ready", ALU_READY, 0);
        applyStimulus();
        MEM_VALID = 1'b0;
        expectWrite(3'd2, 16'h1111);
        @(negedge CLK);
        checkOutput("both_c2_alu_ready", ALU_READY, 1);
        checkOutput("both_c2_pending",   PENDING,   0);
        applyStimulus();
        ALU_VALID = 1'b0;

        // Alternation with both held: MEM, ALU, MEM
        ISSUE_VALID = 1'b1; ISSUE_DR = 3'd0;
        applyStimulus();
        ISSUE_DR = 3'd1;
        applyStimulus();
        ISSUE_VALID = 1'b0;
        ALU_VALID = 1'b1; ALU_DR = 3'd2; ALU_DATA = 16'h1234;
        MEM_VALID = 1'b1; MEM_DR = 3'd0; MEM_DATA = 16'hA000;
        expectWrite(3'd0, 16'hA000);
        @(negedge CLK);
        checkOutput("alt_pending", PENDING, 8'h03);
        checkOutput("alt_c1_mem",  MEM_READY, 1);
        applyStimulus();
        MEM_DR = 3'd1; MEM_DATA = 16'hA001;
        expectWrite(3'd2, 16'h1234);
        @(negedge CLK);
        checkOutput("alt_c2_alu", ALU_READY, 1);
        checkOutput("alt_c2_mem", MEM_READY, 0);
        applyStimulus();
        expectWrite(3'd1, 16'hA001);
        @(negedge CLK);
        checkOutput("alt_c3_mem", MEM_READY, 1);
        checkOutput("alt_c3_alu", ALU_READY, 0);
        applyStimulus();
        ALU_VALID = 1'b0; MEM_VALID = 1'b0;

        // WAW hold: ALU to R3 waits for the outstanding load to R3
        ISSUE_VALID = 1'b1; ISSUE_DR = 3'd3;
        applyStimulus();
        ISSUE_VALID = 1'b0;
        ALU_VALID = 1'b1; ALU_DR = 3'd3; ALU_DATA = 16'h3333;
        @(negedge CLK);
        checkOutput("waw_alu_ready", ALU_READY, 0);
        checkOutput("waw_no_write",  RF_RD_LE,  0);
        checkOutput("waw_pending",   PENDING,   8'h08);
        applyStimulus();
        MEM_VALID = 1'b1; MEM_DR = 3'd3; MEM_DATA = 16'hBEEF;
        expectWrite(3'd3, 16'hBEEF);
        @(negedge CLK);
        checkOutput("waw_mem_ready", MEM_READY, 1);
        checkOutput("waw_alu_held",  ALU_READY, 0);
        applyStimulus();
        checkOutput("waw_r3_beef", modelRegs[3], 16'hBEEF);
        MEM_VALID = 1'b0;
        expectWrite(3'd3, 16'h3333);
        @(negedge CLK);
        checkOutput("waw_alu_after", ALU_READY, 1);
        applyStimulus();
        ALU_VALID = 1'b0;

        // Load limit: third issue held until a load retires
        ISSUE_VALID = 1'b1; ISSUE_DR = 3'd1;
        applyStimulus();
        ISSUE_DR = 3'd4;
        applyStimulus();
        ISSUE_DR = 3'd2;
        @(negedge CLK);
        checkOutput("full_issue_ready", ISSUE_READY, 0);
        applyStimulus();
        MEM_VALID = 1'b1; MEM_DR = 3'd1; MEM_DATA = 16'h0101;
        expectWrite(3'd1, 16'h0101);
        @(negedge CLK);
        checkOutput("full_retire_issue", ISSUE_READY, 1);
        checkOutput("full_retire_mem",   MEM_READY,   1);
        applyStimulus();
        MEM_VALID = 1'b0; ISSUE_DR = 3'd0;
        @(negedge CLK);
        checkOutput("full_pending",   PENDING,     8'h14);
        checkOutput("full_count_two", ISSUE_READY, 0);
        applyStimulus();
        ISSUE_VALID = 1'b0;
        MEM_VALID = 1'b1; MEM_DR = 3'd4; MEM_DATA = 16'h0404;
        expectWrite(3'd4, 16'h0404);
        applyStimulus();
        MEM_DR = 3'd2; MEM_DATA = 16'h0202;
        ISSUE_VALID = 1'b1; ISSUE_DR = 3'd2;
        expectWrite(3'd2, 16'h0202);
        @(negedge CLK);
        checkOutput("same_reg_issue_ready", ISSUE_READY, 1);
        applyStimulus();
        ISSUE_VALID = 1'b0;
        MEM_DATA = 16'h0220;
        expectWrite(3'd2, 16'h0220);
        @(negedge CLK);
        checkOutput("same_reg_set_wins", PENDING, 8'h04);
        applyStimulus();
        MEM_VALID = 1'b0;
        @(negedge CLK);
        checkOutput("drain_pending", PENDING, 0);
        checkOutput("drain_err",     ERR,     0);
        applyStimulus();

        // Source hazard on R6 and release in the retiring cycle
        ISSUE_VALID = 1'b1; ISSUE_DR = 3'd6;
        applyStimulus();
        ISSUE_VALID = 1'b0;
        RS1_USE = 1'b1; RS1 = 3'd6;
        @(negedge CLK);
        checkOutput("raw_rs1_stall", RD_STALL, 1);
        checkOutput("raw_rf_rs1",    RF_RS1,   3'd6);
        applyStimulus();
        RS1_USE = 1'b0; RS2_USE = 1'b1; RS2 = 3'd6;
        @(negedge CLK);
        checkOutput("raw_rs2_stall", RD_STALL, 1);
        checkOutput("raw_rf_rs2",    RF_RS2,   3'd6);
        applyStimulus();
        MEM_VALID = 1'b1; MEM_DR = 3'd6; MEM_DATA = 16'h6666;
        expectWrite(3'd6, 16'h6666);
        @(negedge CLK);
        checkOutput("raw_release", RD_STALL, 0);
        applyStimulus();
        MEM_VALID = 1'b0;
        checkOutput("raw_r6_data", modelRegs[6], 16'h6666);
        @(negedge CLK);
        checkOutput("raw_after", RD_STALL, 0);
        applyStimulus();
        RS2_USE = 1'b0;

        // Spurious load writeback: write still happens, ERR sticks
        MEM_VALID = 1'b1; MEM_DR = 3'd7; MEM_DATA = 16'h7777;
        expectWrite(3'd7, 16'h7777);
        @(negedge CLK);
        checkOutput("err_mem_ready", MEM_READY, 1);
        checkOutput("err_not_yet",   ERR,       0);
        applyStimulus();
        MEM_VALID = 1'b0;
        @(negedge CLK);
        checkOutput("err_set",        ERR,         1);
        checkOutput("err_no_underflow", ISSUE_READY, 1);
        applyStimulus();
        ISSUE_VALID = 1'b1; ISSUE_DR = 3'd0;
        @(negedge CLK);
        checkOutput("err_sticky", ERR, 1);
        applyStimulus();
        ISSUE_VALID = 1'b0;
        @(negedge CLK);
        checkOutput("pre_rst_pending", PENDING, 8'h01);
        applyStimulus();

        // Reset pulse clears everything and restores LAST_GRANT=ALU
        RST = 1'b1;
        applyStimulus();
        RST = 1'b0;
        @(negedge CLK);
        checkOutput("rst2_err",     ERR,     0);
        checkOutput("rst2_pending", PENDING, 0);
        applyStimulus();
        ISSUE_VALID = 1'b1; ISSUE_DR = 3'd7;
        applyStimulus();
        ISSUE_VALID = 1'b0;
        ALU_VALID = 1'b1; ALU_DR = 3'd2; ALU_DATA = 16'hA1A1;
        MEM_VALID = 1'b1; MEM_DR = 3'd7; MEM_DATA = 16'hB2B2;
        expectWrite(3'd7, 16'hB2B2);
        @(negedge CLK);
        checkOutput("rst2_mem_first", MEM_READY, 1);
        checkOutput("rst2_alu_wait",  ALU_READY, 0);
        applyStimulus();
        MEM_VALID = 1'b0;
        expectWrite(3'd2, 16'hA1A1);
        @(negedge CLK);
        checkOutput("rst2_alu_next", ALU_READY, 1);
        applyStimulus();
        ALU_VALID = 1'b0;
        applyStimulus();

        // Final register contents and leftover expectations
        checkOutput("final_r3", modelRegs[3], 16'h3333);
        checkOutput("final_r5", modelRegs[5], 16'h2222);
        checkOutput("final_r7", modelRegs[7], 16'hB2B2);
        checkOutput("final_queue_empty", expQ.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", checksDone, checksFailed);
        $finish;
    end

endmodule
